wmem_lane_bank: RTL and testbench



---
 rtl/wmem_pkg.sv | 28 ++
 rtl/wmem_bank.sv | 34 +++
 rtl/wmem_lane_bank.sv | 228 ++++++++++++++++++++++
 tb/tb_wmem_lane_bank.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wmem_pkg.sv
// Shared types and sizing helpers for the banked hidden-layer weight memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    // Index width that stays at least 1 bit for 1- and 2-entry dimensions.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Default geometry of the production configuration.
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_N_IN     = 128;
    localparam int DEF_N_HIDDEN = 64;
    localparam int DEF_N_LAYERS = 3;
    localparam int DEF_N_LANES  = 4;

    localparam int G          = DEF_N_HIDDEN / DEF_N_LANES;
    localparam int BANK_DEPTH = DEF_N_LAYERS * G * DEF_N_IN;
    localparam int BANK_AW    = safe_clog2(BANK_DEPTH);

endpackage

// File: rtl/wmem_bank.sv
// One weight bank: simple dual-port RAM, one write port, one registered read port.
// Latency: read data registered one cycle after re; read-first on same-address collision.
// Backpressure: none; both ports accept every cycle.
module wmem_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; sees the pre-write contents on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wmem_lane_bank.sv
// Banked multi-lane weight memory: host streams a layer in, MAC array reads N_LANES weights/cycle.
// Latency: read 2 cycles (address stage + registered bank output); a write lands 2 edges after its handshake.
// Backpressure: s_ready high only while a layer load is in progress; reads never stall.
module wmem_lane_bank
    import wmem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int N_IN     = DEF_N_IN,
    parameter int N_HIDDEN = DEF_N_HIDDEN,
    parameter int N_LAYERS = DEF_N_LAYERS,
    parameter int N_LANES  = DEF_N_LANES
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      ld_start,
    input  logic [safe_clog2(N_LAYERS)-1:0]           ld_layer,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic signed [DATA_W-1:0]                  s_data,
    output logic                                      ld_done,
    output logic                                      ld_err,
    output logic [N_LAYERS-1:0]                       layer_valid,
    input  logic                                      rd_en,
    input  logic [safe_clog2(N_LAYERS)-1:0]           rd_layer,
    input  logic [safe_clog2(N_HIDDEN/N_LANES)-1:0]   rd_group,
    input  logic [safe_clog2(N_IN)-1:0]               rd_i,
    output logic                                      rd_valid,
    output logic [N_LANES*DATA_W-1:0]                 rd_data
);

    localparam int GRP         = N_HIDDEN / N_LANES;
    localparam int LAYER_WORDS = GRP * N_IN;
    localparam int DEPTH       = N_LAYERS * LAYER_WORDS;
    localparam int AW          = safe_clog2(DEPTH);
    localparam int LW          = safe_clog2(N_LAYERS);
    localparam int GW          = safe_clog2(GRP);
    localparam int IW          = safe_clog2(N_IN);
    localparam int HW          = safe_clog2(N_HIDDEN);
    localparam int KW          = safe_clog2(N_LANES);

    ld_state_t         state_q, state_d;
    logic [LW-1:0]     layer_q;
    logic [HW-1:0]     h_q;
    logic [IW-1:0]     i_q;
    logic [KW-1:0]     bank_q;
    logic [AW-1:0]     grp_base_q;
    logic [AW-1:0]     ld_base;

    logic              accept;
    logic              hs;
    logic              last_word;

    logic              wr_vld;
    logic [KW-1:0]     wr_bank;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_dat;

    logic              rd_oor;
    logic [AW-1:0]     rd_addr;
    logic              s1_vld;
    logic              s1_oor;
    logic [AW-1:0]     s1_addr;
    logic              zero_q;
    logic [DATA_W-1:0] bank_rd [N_LANES];

    assign accept    = ld_start && (state_q == IDLE) &&
                       ({1'b0, ld_layer} < (LW+1)'(N_LAYERS));
    assign hs        = s_valid && (state_q == LOAD);
    assign last_word = hs && (h_q == HW'(N_HIDDEN - 1)) && (i_q == IW'(N_IN - 1));

    // Base address of the requested layer as a mux of constants (no multiplier on the write side).
    always_comb begin
        ld_base = '0;
        for (int j = 0; j < N_LAYERS; j++) begin
            if (LW'(j) == ld_layer) begin
                ld_base = AW'(j * LAYER_WORDS);
            end
        end
    end

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load FSM next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        ld_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ld_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write address counters: i innermost, then bank (h % N_LANES), then lane-group base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q    <= '0;
            h_q        <= '0;
            i_q        <= '0;
            bank_q     <= '0;
            grp_base_q <= '0;
        end else if (accept) begin
            layer_q    <= ld_layer;
            h_q        <= '0;
            i_q        <= '0;
            bank_q     <= '0;
            grp_base_q <= ld_base;
        end else if (hs) begin
            if (i_q == IW'(N_IN - 1)) begin
                i_q <= '0;
                h_q <= h_q + HW'(1);
                if (bank_q == KW'(N_LANES - 1)) begin
                    bank_q     <= '0;
                    grp_base_q <= grp_base_q + AW'(N_IN);
                end else begin
                    bank_q <= bank_q + KW'(1);
                end
            end else begin
                i_q <= i_q + IW'(1);
            end
        end
    end

    // Register the write so a read in the handshake cycle still sees the previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld  <= 1'b0;
            wr_bank <= '0;
            wr_addr <= '0;
            wr_dat  <= '0;
        end else begin
            wr_vld <= hs;
            if (hs) begin
                wr_bank <= bank_q;
                wr_addr <= grp_base_q + AW'(i_q);
                wr_dat  <= s_data;
            end
        end
    end

    // Per-layer loaded flags and rejected-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_valid <= '0;
            ld_err      <= 1'b0;
        end else begin
            ld_err <= ld_start && !accept;
            if (accept) begin
                layer_valid[ld_layer] <= 1'b0;
            end
            if (last_word) begin
                layer_valid[layer_q] <= 1'b1;
            end
        end
    end

    assign rd_oor  = ({1'b0, rd_layer} >= (LW+1)'(N_LAYERS)) ||
                     ({1'b0, rd_group} >= (GW+1)'(GRP));
    assign rd_addr = AW'(int'(rd_layer) * LAYER_WORDS + int'(rd_group) * N_IN + int'(rd_i));

    // Read stage 1: local address and range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_oor  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_vld <= rd_en;
            if (rd_en) begin
                s1_oor  <= rd_oor;
                s1_addr <= rd_addr;
            end
        end
    end

    // Read stage 2 control: valid flag and output-zeroing (reset and out-of-range reads).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            rd_valid <= s1_vld;
            if (s1_vld) begin
                zero_q <= s1_oor;
            end
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_bank
        wmem_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .clk   (clk),
            .we    (wr_vld && (wr_bank == KW'(k))),
            .waddr (wr_addr),
            .wdata (wr_dat),
            .re    (s1_vld && !s1_oor),
            .raddr (s1_addr),
            .rdata (bank_rd[k])
        );

        assign rd_data[k*DATA_W +: DATA_W] = zero_q ? '0 : bank_rd[k];
    end

endmodule

// File: tb/tb_wmem_lane_bank.sv
// Self-checking bench: small geometry (4 inputs, 8 hidden, 3 layers, 4 lanes).
// Three layers keep ld_layer 2 bits wide so an out-of-range layer index is expressible.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_wmem_lane_bank;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NH = 8;
    localparam int NL = 3;
    localparam int NK = 4;
    localparam int WORDS = NH * NI;

    logic              clk;
    logic              rst_n;
    logic              ld_start;
    logic [1:0]        ld_layer;
    logic              s_valid;
    logic              s_ready;
    logic signed [DW-1:0] s_data;
    logic              ld_done;
    logic              ld_err;
    logic [NL-1:0]     layer_valid;
    logic              rd_en;
    logic [1:0]        rd_layer;
    logic [0:0]        rd_group;
    logic [1:0]        rd_i;
    logic              rd_valid;
    logic [NK*DW-1:0]  rd_data;

    wmem_lane_bank #(
        .DATA_W   (DW),
        .N_IN     (NI),
        .N_HIDDEN (NH),
        .N_LAYERS (NL),
        .N_LANES  (NK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_start    (ld_start),
        .ld_layer    (ld_layer),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .ld_done     (ld_done),
        .ld_err      (ld_err),
        .layer_valid (layer_valid),
        .rd_en       (rd_en),
        .rd_layer    (rd_layer),
        .rd_group    (rd_group),
        .rd_i        (rd_i),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: weight array indexed (layer, neuron, input) plus protocol status.
    logic [DW-1:0]    m_mem   [NL][NH][NI];
    bit               m_known [NL][NH][NI];
    bit               m_loading = 0;
    bit               m_done    = 0;
    bit               m_err     = 0;
    int               m_layer   = 0;
    int               m_cnt     = 0;
    logic [NL-1:0]    m_lv      = '0;
    bit               rv1 = 0, rv2 = 0;
    logic [NK*DW-1:0] rd1 = '0, rd2 = '0;
    bit               rk1 = 1, rk2 = 1;
    logic [NK*DW-1:0] last  = '0;
    bit               lastk = 1;

    typedef struct {
        logic [1:0]       layer;
        logic [0:0]       grp;
        logic [1:0]       idx;
        logic [NK*DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [8];

    function automatic logic [NK*DW-1:0] lanes(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Word value for stream position n (h-major, i-minor).
    function automatic logic [DW-1:0] word_val(input int mode, input int n);
        int h = n / NI;
        int i = n % NI;
        if (mode == 0) return 16'(100 * h + i);
        if (mode == 1) return 16'($urandom_range(0, 16'h7FFF));
        return 16'(-1 - n);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs the DUT is sampling.
    task automatic model_edge();
        bit hs;
        bit acc;
        bit done_n = 0;
        bit err_n  = 0;
        if (!rst_n) begin
            if (m_loading) begin
                for (int h = 0; h < NH; h++)
                    for (int i = 0; i < NI; i++) m_known[m_layer][h][i] = 0;
            end
            m_loading = 0; m_done = 0; m_err = 0; m_lv = '0; m_cnt = 0;
            rv1 = 0; rv2 = 0; last = '0; lastk = 1;
            return;
        end
        rv2 = rv1; rd2 = rd1; rk2 = rk1;
        rv1 = rd_en;
        if (rd_en) begin
            rd1 = '0; rk1 = 1;
            if (int'(rd_layer) < NL) begin
                for (int k = 0; k < NK; k++) begin
                    int h = int'(rd_group) * NK + k;
                    rd1[k*DW +: DW] = m_mem[int'(rd_layer)][h][int'(rd_i)];
                    if (!m_known[int'(rd_layer)][h][int'(rd_i)]) rk1 = 0;
                end
            end
        end
        if (rv2) begin last = rd2; lastk = rk2; end

        hs  = s_valid && m_loading;
        acc = 0;
        if (ld_start) begin
            if (!m_loading && !m_done && int'(ld_layer) < NL) acc = 1;
            else err_n = 1;
        end
        if (hs) begin
            m_mem[m_layer][m_cnt / NI][m_cnt % NI]   = s_data;
            m_known[m_layer][m_cnt / NI][m_cnt % NI] = 1;
            m_cnt++;
            if (m_cnt == WORDS) begin
                m_loading = 0;
                done_n = 1;
                m_lv[m_layer] = 1'b1;
            end
        end
        if (acc) begin
            m_loading = 1;
            m_cnt = 0;
            m_layer = int'(ld_layer);
            m_lv[m_layer] = 1'b0;
        end
        m_done = done_n;
        m_err  = err_n;
    endtask

    task automatic check_outputs();
        chk("s_ready", 64'(s_ready), 64'(m_loading));
        chk("ld_done", 64'(ld_done), 64'(m_done));
        chk("ld_err", 64'(ld_err), 64'(m_err));
        chk("layer_valid", 64'(layer_valid), 64'(m_lv));
        chk("rd_valid", 64'(rd_valid), 64'(rv2));
        if (lastk) chk("rd_data", rd_data, last);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    // Feed words until ld_done (bounded); optionally fire one ld_start mid-load.
    task automatic stream(input int mode, input bit rnd, input int inject_at, output int nsteps);
        bit injected = 0;
        nsteps = 0;
        while (!ld_done && nsteps < 400) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = word_val(mode, m_cnt);
            if (!injected && m_cnt == inject_at) begin
                ld_start = 1'b1; ld_layer = 2'd0; injected = 1;
            end
            step();
            nsteps++;
            if (ld_start) begin
                chk("ld_err_busy", 64'(ld_err), 64'd1);
                ld_start = 1'b0;
            end
        end
        s_valid = 1'b0;
        chk("ld_done_seen", 64'(ld_done), 64'd1);
    endtask

    task automatic start_load(input int layer);
        ld_start = 1'b1; ld_layer = 2'(layer);
        step();
        ld_start = 1'b0;
    endtask

    task automatic readback(input int n);
        for (int j = 0; j < n; j++) begin
            rd_en    = 1'($urandom_range(0, 3) != 0);
            rd_layer = 2'($urandom_range(0, 3));
            rd_group = 1'($urandom_range(0, 1));
            rd_i     = 2'($urandom_range(0, 3));
            step();
        end
        rd_en = 1'b0;
        step();
        step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_ld_done"}, 64'(ld_done), 64'd0);
        chk({tag, "_ld_err"}, 64'(ld_err), 64'd0);
        chk({tag, "_layer_valid"}, 64'(layer_valid), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, rd_data, 64'd0);
    endtask

    initial begin
        int ns;
        logic [DW-1:0] old0;

        tbl[0] = '{2'd1, 1'b1, 2'd3, lanes(403, 503, 603, 703)};
        tbl[1] = '{2'd1, 1'b1, 2'd0, lanes(400, 500, 600, 700)};
        tbl[2] = '{2'd1, 1'b1, 2'd1, lanes(401, 501, 601, 701)};
        tbl[3] = '{2'd1, 1'b1, 2'd2, lanes(402, 502, 602, 702)};
        tbl[4] = '{2'd1, 1'b1, 2'd3, lanes(403, 503, 603, 703)};
        tbl[5] = '{2'd1, 1'b0, 2'd2, lanes(2, 102, 202, 302)};
        tbl[6] = '{2'd3, 1'b0, 2'd1, lanes(0, 0, 0, 0)};
        tbl[7] = '{2'd1, 1'b0, 2'd0, lanes(0, 100, 200, 300)};

        for (int l = 0; l < NL; l++)
            for (int h = 0; h < NH; h++)
                for (int i = 0; i < NI; i++) begin
                    m_mem[l][h][i] = '0; m_known[l][h][i] = 0;
                end

        rst_n = 1'b0; ld_start = 1'b0; ld_layer = '0; s_valid = 1'b0; s_data = '0;
        rd_en = 1'b0; rd_layer = '0; rd_group = '0; rd_i = '0;
        #2;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Out-of-range layer index is rejected and the FSM stays idle.
        ld_start = 1'b1; ld_layer = 2'd3;
        step();
        chk("oor_ld_err", 64'(ld_err), 64'd1);
        chk("oor_s_ready", 64'(s_ready), 64'd0);
        ld_start = 1'b0;
        step();
        chk("oor_err_one_cycle", 64'(ld_err), 64'd0);
        chk("oor_still_idle", 64'(s_ready), 64'd0);

        // Layer 1 with 100*h+i, continuous valid, plus an ignored ld_start mid-load.
        start_load(1);
        chk("load_s_ready", 64'(s_ready), 64'd1);
        stream(0, 1'b0, 5, ns);
        chk("ld_done_latency", 64'(ns + 1), 64'd33);
        chk("layer_valid_l1", 64'(layer_valid), 64'b010);
        step();
        chk("done_one_cycle", 64'(ld_done), 64'd0);

        // Table-driven back-to-back reads; data lands two cycles after each request.
        for (int j = 0; j < 9; j++) begin
            if (j < 8) begin
                rd_en = 1'b1; rd_layer = tbl[j].layer; rd_group = tbl[j].grp; rd_i = tbl[j].idx;
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (j >= 1) begin
                chk("tbl_rd_valid", 64'(rd_valid), 64'd1);
                chk("tbl_rd_data", rd_data, tbl[j-1].exp);
            end
        end
        step();
        chk("tbl_drained", 64'(rd_valid), 64'd0);
        chk("tbl_hold", rd_data, tbl[7].exp);

        // Layer 0 with random data and random valid gaps.
        start_load(0);
        stream(1, 1'b1, -1, ns);
        chk("layer_valid_l01", 64'(layer_valid), 64'b011);
        readback(60);

        // Reload layer 0 while reading the word being written in the same cycle.
        old0 = m_mem[0][0][0];
        start_load(0);
        chk("reload_clears_valid", 64'(layer_valid), 64'b010);
        s_valid = 1'b1; s_data = word_val(2, 0);
        rd_en = 1'b1; rd_layer = 2'd0; rd_group = 1'b0; rd_i = 2'd0;
        step();
        s_data = word_val(2, 1);
        step();
        chk("coll_read_old", 64'(rd_data[DW-1:0]), 64'(old0));
        rd_en = 1'b0; s_data = word_val(2, 2);
        step();
        chk("coll_next_new", 64'(rd_data[DW-1:0]), 64'hFFFF);
        stream(2, 1'b1, -1, ns);
        readback(60);

        // Reset in the middle of loading layer 2.
        start_load(2);
        for (int j = 0; j < 10; j++) begin
            s_valid = 1'b1; s_data = word_val(0, m_cnt);
            step();
        end
        rd_en = 1'b1; rd_layer = 2'd1; rd_group = 1'b1; rd_i = 2'd1;
        step();
        rd_en = 1'b0; s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        start_load(2);
        stream(0, 1'b1, -1, ns);
        chk("layer_valid_after_rst", 64'(layer_valid), 64'b100);
        readback(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
